multicycle_ctrl: RTL and testbench

- Multi-cycle sequencer for the 16-bit, 16-register CPU datapath with 20-bit instructions: 4-bit opcode in [19:16], rs/rt/rd nibbles, funct in [3:0], imm8 in [7:0].
- Walks each instruction through FETCH/DECODE/EXEC/MEM/WB and drives every datapath strobe.
- Performs req/ready handshakes with instruction and data memory, and counts retired instructions.
- Replaces the single-cycle control unit at the top level.

---
 rtl/cpu_ctrl_pkg.sv | 56 +++++
 rtl/multicycle_ctrl_if.sv | 25 ++
 rtl/ctrl_wait_timer.sv | 45 ++++
 rtl/multicycle_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_ctrl_pkg
//  Purpose  : Shared encodings for the multi-cycle CPU sequencer: opcodes,
//             sequencer states, ALU operation codes and PC source selects.
//  Revision : 1.0 - initial release
// ============================================================================
package cpu_ctrl_pkg;

    // Instruction opcodes, IR[19:16]
    localparam logic [3:0] c_OP_RTYPE = 4'h0;
    localparam logic [3:0] c_OP_ADDI  = 4'h1;
    localparam logic [3:0] c_OP_LW    = 4'h2;
    localparam logic [3:0] c_OP_SW    = 4'h3;
    localparam logic [3:0] c_OP_BEQ   = 4'h4;
    localparam logic [3:0] c_OP_JMP   = 4'h5;
    localparam logic [3:0] c_OP_HALT  = 4'hF;

    // Sequencer state encoding
    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_FETCH  = 3'd1;
    localparam logic [2:0] c_ST_DECODE = 3'd2;
    localparam logic [2:0] c_ST_EXEC   = 3'd3;
    localparam logic [2:0] c_ST_MEM    = 3'd4;
    localparam logic [2:0] c_ST_WB     = 3'd5;
    localparam logic [2:0] c_ST_HALT   = 3'd6;

    typedef enum logic [2:0] {
        ST_IDLE   = c_ST_IDLE,
        ST_FETCH  = c_ST_FETCH,
        ST_DECODE = c_ST_DECODE,
        ST_EXEC   = c_ST_EXEC,
        ST_MEM    = c_ST_MEM,
        ST_WB     = c_ST_WB,
        ST_HALT   = c_ST_HALT
    } state_t;

    // ALU operation select
    localparam logic [2:0] c_ALU_ADD   = 3'd0;
    localparam logic [2:0] c_ALU_SUB   = 3'd1;
    localparam logic [2:0] c_ALU_FUNCT = 3'd2;

    // PC source select
    localparam logic [1:0] c_PC_INC    = 2'd0;
    localparam logic [1:0] c_PC_BRANCH = 2'd1;
    localparam logic [1:0] c_PC_JUMP   = 2'd2;

    // True for every opcode the datapath implements
    function automatic logic is_legal_op(input logic [3:0] op);
        return (op == c_OP_RTYPE) || (op == c_OP_ADDI) || (op == c_OP_LW) ||
               (op == c_OP_SW)    || (op == c_OP_BEQ)  || (op == c_OP_JMP) ||
               (op == c_OP_HALT);
    endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_ctrl_if
//  Purpose  : Instruction/data memory handshake between the sequencer
//             (master) and the memory subsystem (slave).
//  Revision : 1.0 - initial release
// ============================================================================
interface multicycle_ctrl_if;
    logic imem_req;
    logic imem_ready;
    logic dmem_ready;
    logic memread;
    logic memwrite;

    modport master (
        output imem_req, memread, memwrite,
        input  imem_ready, dmem_ready
    );

    modport slave (
        input  imem_req, memread, memwrite,
        output imem_ready, dmem_ready
    );
endinterface
`default_nettype wire

// File: rtl/ctrl_wait_timer.sv
`default_nettype none
// ============================================================================
//  Module   : ctrl_wait_timer
//  Purpose  : Counts consecutive wait cycles; expired is asserted on the
//             TIMEOUT-th consecutive enabled cycle. TIMEOUT = 0 disables it.
//  Revision : 1.0 - initial release
// ============================================================================
module ctrl_wait_timer #(
    parameter int TIMEOUT = 15
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic clr,
    input  wire logic en,
    output logic      expired
);

    generate
        if (TIMEOUT > 0) begin : g_enabled
            localparam int c_CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
            localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(TIMEOUT - 1);

            logic [c_CNT_W-1:0] r_cnt;

            // Count prior wait cycles, saturating at the expiry point
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_cnt <= '0;
                end else if (clr) begin
                    r_cnt <= '0;
                end else if (en && (r_cnt != c_LAST)) begin
                    r_cnt <= r_cnt + c_CNT_W'(1);
                end
            end

            assign expired = en && (r_cnt == c_LAST);
        end else begin : g_disabled
            logic w_unused;
            assign w_unused = ^{clk, rst_n, clr, en};
            assign expired  = 1'b0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_ctrl
//  Purpose  : Multi-cycle sequencer for the 16-bit CPU. Steps each
//             instruction through FETCH/DECODE/EXEC/MEM/WB, drives the
//             datapath strobes, handshakes with memory and counts retires.
//  Revision : 1.0 - initial release
// ============================================================================
module multicycle_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 15
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             start,
    input  wire logic [3:0]       opcode,
    input  wire logic             zero,
    multicycle_ctrl_if.master     mem,
    output logic                  ir_write,
    output logic                  pc_write,
    output logic [1:0]            pc_src,
    output logic                  regwrite,
    output logic                  regdst,
    output logic                  alusrc,
    output logic [2:0]            aluop,
    output logic                  memtoreg,
    output logic                  busy,
    output logic                  halted,
    output logic                  fault,
    output logic                  illegal_op,
    output logic [CNT_W-1:0]      retired
);

    state_t             r_state;
    state_t             w_next_state;
    logic [CNT_W-1:0]   r_retired;
    logic               r_fault;
    logic               w_retire;
    logic               w_set_fault;
    logic               w_timer_en;
    logic               w_expired;
    logic               w_imem_req;
    logic               w_memread;
    logic               w_memwrite;
    logic               w_idle_or_halt;

    assign w_idle_or_halt = (r_state == ST_IDLE) || (r_state == ST_HALT);

    // Only ready-less cycles in FETCH or MEM count toward the memory timeout
    assign w_timer_en = ((r_state == ST_FETCH) && !mem.imem_ready) ||
                        ((r_state == ST_MEM)   && !mem.dmem_ready);

    ctrl_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (!w_timer_en),
        .en      (w_timer_en),
        .expired (w_expired)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and strobe decode from current state plus opcode
    always_comb begin
        w_next_state = r_state;
        w_retire     = 1'b0;
        w_set_fault  = 1'b0;
        w_imem_req   = 1'b0;
        w_memread    = 1'b0;
        w_memwrite   = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        pc_src       = c_PC_INC;
        regwrite     = 1'b0;
        regdst       = 1'b0;
        alusrc       = 1'b0;
        aluop        = c_ALU_ADD;
        memtoreg     = 1'b0;
        illegal_op   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (start) w_next_state = ST_FETCH;
            end
            ST_FETCH: begin
                w_imem_req = 1'b1;
                if (mem.imem_ready) begin
                    ir_write     = 1'b1;
                    pc_write     = 1'b1;
                    pc_src       = c_PC_INC;
                    w_next_state = ST_DECODE;
                end else if (w_expired) begin
                    w_set_fault  = 1'b1;
                    w_next_state = ST_HALT;
                end
            end
            ST_DECODE: begin
                if (opcode == c_OP_HALT) begin
                    w_retire     = 1'b1;
                    w_next_state = ST_HALT;
                end else if (!is_legal_op(opcode)) begin
                    illegal_op   = 1'b1;
                    w_next_state = ST_FETCH;
                end else begin
                    w_next_state = ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (opcode)
                    c_OP_RTYPE: begin
                        aluop        = c_ALU_FUNCT;
                        w_next_state = ST_WB;
                    end
                    c_OP_ADDI: begin
                        alusrc       = 1'b1;
                        w_next_state = ST_WB;
                    end
                    c_OP_LW, c_OP_SW: begin
                        alusrc       = 1'b1;
                        w_next_state = ST_MEM;
                    end
                    c_OP_BEQ: begin
                        aluop = c_ALU_SUB;
                        if (zero) begin
                            pc_write = 1'b1;
                            pc_src   = c_PC_BRANCH;
                        end
                        w_retire     = 1'b1;
                        w_next_state = ST_FETCH;
                    end
                    c_OP_JMP: begin
                        pc_write     = 1'b1;
                        pc_src       = c_PC_JUMP;
                        w_retire     = 1'b1;
                        w_next_state = ST_FETCH;
                    end
                    default: w_next_state = ST_FETCH;
                endcase
            end
            ST_MEM: begin
                // Only loads and stores reach MEM, so the opcode picks read/write
                if (opcode == c_OP_LW) w_memread  = 1'b1;
                else                   w_memwrite = 1'b1;
                if (mem.dmem_ready) begin
                    if (opcode == c_OP_LW) begin
                        w_next_state = ST_WB;
                    end else begin
                        w_retire     = 1'b1;
                        w_next_state = ST_FETCH;
                    end
                end else if (w_expired) begin
                    w_set_fault  = 1'b1;
                    w_next_state = ST_HALT;
                end
            end
            ST_WB: begin
                regwrite     = 1'b1;
                regdst       = (opcode == c_OP_RTYPE);
                memtoreg     = (opcode == c_OP_LW);
                w_retire     = 1'b1;
                w_next_state = ST_FETCH;
            end
            ST_HALT: begin
                if (start) w_next_state = ST_FETCH;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Retired-instruction counter, wraps naturally at 2^CNT_W
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_retired <= '0;
        end else if (w_retire) begin
            r_retired <= r_retired + CNT_W'(1);
        end
    end

    // Sticky timeout flag, cleared when a start is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fault <= 1'b0;
        end else if (w_set_fault) begin
            r_fault <= 1'b1;
        end else if (start && w_idle_or_halt) begin
            r_fault <= 1'b0;
        end
    end

    assign mem.imem_req = w_imem_req;
    assign mem.memread  = w_memread;
    assign mem.memwrite = w_memwrite;
    assign busy         = !w_idle_or_halt;
    assign halted       = (r_state == ST_HALT);
    assign fault        = r_fault;
    assign retired      = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multicycle_ctrl
//  Purpose  : Directed self-checking bench for the multi-cycle sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [3:0]  opcode;
    logic        zero;
    logic        ir_write;
    logic        pc_write;
    logic [1:0]  pc_src;
    logic        regwrite;
    logic        regdst;
    logic        alusrc;
    logic [2:0]  aluop;
    logic        memtoreg;
    logic        busy;
    logic        halted;
    logic        fault;
    logic        illegal_op;
    logic [15:0] retired;

    int n_tests = 0;
    int n_fail  = 0;
    int cnt     = 0;

    multicycle_ctrl_if mif ();

    multicycle_ctrl #(
        .CNT_W   (16),
        .TIMEOUT (15)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .opcode     (opcode),
        .zero       (zero),
        .mem        (mif.master),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .regwrite   (regwrite),
        .regdst     (regdst),
        .alusrc     (alusrc),
        .aluop      (aluop),
        .memtoreg   (memtoreg),
        .busy       (busy),
        .halted     (halted),
        .fault      (fault),
        .illegal_op (illegal_op),
        .retired    (retired)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; opcode = 4'h0; zero = 1'b0;
        mif.imem_ready = 1'b0; mif.dmem_ready = 1'b0;
        #3;
        check("rst_busy",    busy, 0);
        check("rst_halted",  halted, 0);
        check("rst_retired", retired, 0);
        check("rst_fault",   fault, 0);
        check("rst_imemreq", mif.imem_req, 0);
        check("rst_aluop",   aluop, 0);
        tick(); tick();
        rst_n = 1'b1;

        // RTYPE, zero-wait memories
        mif.imem_ready = 1'b1; mif.dmem_ready = 1'b1; opcode = 4'h0;
        start = 1'b1;
        tick(); start = 1'b0; #1;                       // cycle 1: FETCH
        check("rt_imem_req", mif.imem_req, 1);
        check("rt_ir_write", ir_write, 1);
        check("rt_pc_write", pc_write, 1);
        tick(); #1;                                     // cycle 2: DECODE
        check("rt_dec_irw", ir_write, 0);
        tick(); #1;                                     // cycle 3: EXEC
        check("rt_aluop", aluop, 2);
        check("rt_alusrc", alusrc, 0);
        tick(); #1;                                     // cycle 4: WB
        check("rt_regwrite", regwrite, 1);
        check("rt_regdst", regdst, 1);
        check("rt_memtoreg", memtoreg, 0);
        tick(); #1;                                     // next FETCH
        check("rt_retired", retired, 1);

        // LW, dmem_ready late by two cycles
        opcode = 4'h2; mif.dmem_ready = 1'b0;
        tick(); #1;                                     // DECODE
        tick(); #1;                                     // EXEC
        check("lw_aluop", aluop, 0);
        check("lw_alusrc", alusrc, 1);
        cnt = 0;
        tick(); #1; if (mif.memread) cnt++;             // MEM wait 1
        tick(); #1; if (mif.memread) cnt++;             // MEM wait 2
        tick(); mif.dmem_ready = 1'b1; #1;              // MEM ready
        if (mif.memread) cnt++;
        check("lw_memread_cycles", cnt, 3);
        tick(); #1;                                     // WB
        check("lw_memtoreg", memtoreg, 1);
        check("lw_regwrite", regwrite, 1);
        check("lw_regdst", regdst, 0);
        check("lw_retired_before", retired, 1);
        tick(); #1;
        check("lw_retired", retired, 2);

        // BEQ taken then not taken
        opcode = 4'h4; zero = 1'b1;
        tick(); tick(); #1;                             // EXEC
        check("beq1_aluop", aluop, 1);
        check("beq1_pc_write", pc_write, 1);
        check("beq1_pc_src", pc_src, 1);
        tick(); #1;
        check("beq1_retired", retired, 3);
        zero = 1'b0;
        tick(); tick(); #1;                             // EXEC
        check("beq0_pc_write", pc_write, 0);
        check("beq0_pc_src", pc_src, 0);
        tick(); #1;
        check("beq0_retired", retired, 4);

        // JMP
        opcode = 4'h5;
        tick(); tick(); #1;                             // EXEC
        check("jmp_pc_write", pc_write, 1);
        check("jmp_pc_src", pc_src, 2);
        tick(); #1;
        check("jmp_retired", retired, 5);

        // Illegal opcode 7
        opcode = 4'h7;
        tick(); #1;                                     // DECODE
        check("ill_pulse", illegal_op, 1);
        tick(); #1;                                     // back in FETCH
        check("ill_pulse_end", illegal_op, 0);
        check("ill_refetch", ir_write, 1);
        check("ill_retired", retired, 5);

        // HALT, with start asserted while busy
        opcode = 4'hF;
        tick(); start = 1'b1; #1;                       // DECODE
        tick(); start = 1'b0; #1;                       // HALT
        check("hlt_halted", halted, 1);
        check("hlt_busy", busy, 0);
        check("hlt_retired", retired, 6);
        tick(); #1;
        check("hlt_stays", halted, 1);

        // Fetch timeout
        mif.imem_ready = 1'b0; start = 1'b1;
        tick(); start = 1'b0; #1;                       // FETCH cycle 1
        cnt = 0;
        if (ir_write) cnt++;
        for (int i = 2; i <= 15; i++) begin
            tick(); #1;
            if (ir_write || halted) cnt++;
        end
        check("to_no_early_halt", cnt, 0);
        tick(); #1;                                     // cycle 16
        check("to_fault", fault, 1);
        check("to_halted", halted, 1);
        check("to_retired", retired, 6);

        // Restart; ready arrives on the 15th wait cycle and wins
        start = 1'b1;
        tick(); start = 1'b0; #1;                       // FETCH cycle 1
        check("rs_fault_clr", fault, 0);
        check("rs_imem_req", mif.imem_req, 1);
        for (int i = 2; i <= 14; i++) tick();
        tick(); mif.imem_ready = 1'b1; #1;              // cycle 15
        check("rs_ir_write", ir_write, 1);
        opcode = 4'h3;
        tick(); #1;                                     // DECODE
        check("rs_no_fault", fault, 0);
        check("rs_busy", busy, 1);

        // SW stalled in MEM, then asynchronous reset
        mif.dmem_ready = 1'b0;
        tick(); tick(); #1;                             // MEM
        check("sw_memwrite", mif.memwrite, 1);
        rst_n = 1'b0; #1;
        check("ar_memwrite", mif.memwrite, 0);
        check("ar_busy", busy, 0);
        check("ar_retired", retired, 0);
        tick();
        rst_n = 1'b1;

        // Resume after reset with a zero-wait SW
        mif.dmem_ready = 1'b1; mif.imem_ready = 1'b1; start = 1'b1;
        tick(); start = 1'b0; #1;
        check("post_fetch", ir_write, 1);
        tick(); tick(); tick(); #1;                     // MEM
        check("post_memwrite", mif.memwrite, 1);
        tick(); #1;
        check("post_retired", retired, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
